// File: rtl/csr_unit_if.sv
// ============================================================================
// Module      : csr_unit_if
// Description : CSR request/response bus between the execute stage and csr_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface csr_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic [1:0]      req_op;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            req_wen;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_wen,
    input  rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_wen,
    output rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/csr_unit.sv
// ============================================================================
// Module      : csr_unit
// Description : Machine-mode CSR unit: trap CSRs, NCNT 64-bit counters, irq
//               pending. Optional mcountinhibit via CSR_COUNTER_INHIBIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_unit #(
  parameter int          XLEN     = 32,
  parameter int          NCNT     = 5,
  parameter logic [31:0] HARTID   = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  wire logic            clk,
  input  wire logic            rst,
  csr_unit_if.slave            bus,
  input  wire logic [NCNT-1:0] cnt_inc,
  input  wire logic            trap_valid,
  input  wire logic [XLEN-1:0] trap_cause,
  input  wire logic [XLEN-1:0] trap_pc,
  input  wire logic [XLEN-1:0] trap_val,
  input  wire logic            mret,
  input  wire logic            irq_sw,
  input  wire logic            irq_timer,
  input  wire logic            irq_ext,
  output logic      [XLEN-1:0] mtvec_o,
  output logic      [XLEN-1:0] mepc_o,
  output logic                 irq_pending
);

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;

  typedef enum logic [3:0] {
    SEL_NONE, SEL_MSTATUS, SEL_MIE, SEL_MTVEC, SEL_MSCRATCH, SEL_MEPC,
    SEL_MCAUSE, SEL_MTVAL, SEL_MIP, SEL_CONST, SEL_CNT_LO, SEL_CNT_HI,
    SEL_MCOUNTINH
  } sel_e;

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [2:0]  mip_q, mip_d;
  logic        irq_pending_q, irq_pending_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [63:0] cnt_q [NCNT];
  logic [63:0] cnt_d [NCNT];
  logic [NCNT-1:0] cnt_frozen;

  sel_e        sel;
  logic [4:0]  cnt_k;
  logic [31:0] const_val;
  logic [31:0] old_val;
  logic [31:0] wmask;
  logic [31:0] new_val;
  logic [31:0] stored;
  logic [63:0] cnt_sel;
  logic [31:0] mip_val;
  logic        acc_err;
  logic        do_write;
  logic        trap_or_mret;
  logic        cnt_run;

`ifdef CSR_COUNTER_INHIBIT_EN
  // Bit 1 is never writable, so counter 1 cannot be frozen.
  localparam logic [NCNT-1:0] INH_MASK = NCNT'((64'd1 << NCNT) - 64'd1) & ~NCNT'(2);
  logic [NCNT-1:0] inh_q, inh_d;
  assign cnt_frozen = inh_q;
`else
  assign cnt_frozen = '0;
`endif

  assign mip_val = {20'b0, mip_q[2], 3'b0, mip_q[1], 3'b0, mip_q[0], 3'b0};

  // Address decode
  always_comb begin
    sel       = SEL_NONE;
    cnt_k     = 5'd0;
    const_val = 32'd0;
    case (bus.req_addr)
      12'h300: sel = SEL_MSTATUS;
      12'h304: sel = SEL_MIE;
      12'h305: sel = SEL_MTVEC;
      12'h340: sel = SEL_MSCRATCH;
      12'h341: sel = SEL_MEPC;
      12'h342: sel = SEL_MCAUSE;
      12'h343: sel = SEL_MTVAL;
      12'h344: sel = SEL_MIP;
      12'hF10: begin sel = SEL_CONST; const_val = MISA_VAL; end
      12'hF11, 12'hF12, 12'hF13: sel = SEL_CONST;
      12'hF14: begin sel = SEL_CONST; const_val = HARTID; end
`ifdef CSR_COUNTER_INHIBIT_EN
      12'h320: sel = SEL_MCOUNTINH;
`endif
      default: begin
        // Low halves live at 0xB00..0xB1F, high halves at 0xB80..0xB9F; slot 1 is a hole.
        if (bus.req_addr[11:5] == 7'b101_1000 || bus.req_addr[11:5] == 7'b101_1100) begin
          if (bus.req_addr[4:0] == 5'd0) begin
            sel = bus.req_addr[7] ? SEL_CNT_HI : SEL_CNT_LO;
          end else if (bus.req_addr[4:0] != 5'd1 &&
                       ({1'b0, bus.req_addr[4:0]} - 6'd1) < 6'(NCNT)) begin
            sel   = bus.req_addr[7] ? SEL_CNT_HI : SEL_CNT_LO;
            cnt_k = bus.req_addr[4:0] - 5'd1;
          end
        end
      end
    endcase
  end

  // Old value, write mask and merged store value
  always_comb begin
    cnt_sel = 64'd0;
    for (int i = 0; i < NCNT; i++) begin
      if (cnt_k == 5'(i)) cnt_sel = cnt_q[i];
    end
    old_val = 32'd0;
    wmask   = 32'd0;
    case (sel)
      SEL_MSTATUS:  begin old_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0}; wmask = 32'h0000_0088; end
      SEL_MIE:      begin old_val = mie_q;      wmask = 32'h0000_0888; end
      SEL_MTVEC:    begin old_val = mtvec_q;    wmask = 32'hFFFF_FFFC; end
      SEL_MSCRATCH: begin old_val = mscratch_q; wmask = 32'hFFFF_FFFF; end
      SEL_MEPC:     begin old_val = mepc_q;     wmask = 32'hFFFF_FFFC; end
      SEL_MCAUSE:   begin old_val = mcause_q;   wmask = 32'hFFFF_FFFF; end
      SEL_MTVAL:    begin old_val = mtval_q;    wmask = 32'hFFFF_FFFF; end
      SEL_MIP:      old_val = mip_val;
      SEL_CONST:    old_val = const_val;
      SEL_CNT_LO:   begin old_val = cnt_sel[31:0];  wmask = 32'hFFFF_FFFF; end
      SEL_CNT_HI:   begin old_val = cnt_sel[63:32]; wmask = 32'hFFFF_FFFF; end
`ifdef CSR_COUNTER_INHIBIT_EN
      SEL_MCOUNTINH: begin old_val = 32'(inh_q); wmask = 32'(INH_MASK); end
`endif
      default: ;
    endcase
    case (bus.req_op)
      OP_RW:   new_val = bus.req_wdata;
      OP_RS:   new_val = old_val | bus.req_wdata;
      default: new_val = old_val & ~bus.req_wdata;
    endcase
    stored = (new_val & wmask) | (old_val & ~wmask);
  end

  assign acc_err      = (sel == SEL_NONE) || (sel == SEL_CONST && bus.req_wen);
  assign do_write     = bus.req_valid && bus.req_wen && (bus.req_op != OP_READ) && !acc_err;
  assign trap_or_mret = trap_valid || mret;

  // Next-state logic
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;
`ifdef CSR_COUNTER_INHIBIT_EN
    inh_d          = inh_q;
`endif
    mip_d          = {irq_ext, irq_timer, irq_sw};
    irq_pending_d  = mstatus_mie_q & |(mip_val & mie_q);
    rsp_valid_d    = bus.req_valid;
    rsp_rdata_d    = (bus.req_valid && !acc_err) ? old_val : 32'd0;
    rsp_err_d      = bus.req_valid && acc_err;

    if (do_write) begin
      case (sel)
        SEL_MSTATUS: if (!trap_or_mret) begin
          mstatus_mie_d  = stored[3];
          mstatus_mpie_d = stored[7];
        end
        SEL_MIE:      mie_d      = stored;
        SEL_MTVEC:    mtvec_d    = stored;
        SEL_MSCRATCH: mscratch_d = stored;
        SEL_MEPC:     if (!trap_or_mret) mepc_d   = stored;
        SEL_MCAUSE:   if (!trap_or_mret) mcause_d = stored;
        SEL_MTVAL:    if (!trap_or_mret) mtval_d  = stored;
`ifdef CSR_COUNTER_INHIBIT_EN
        SEL_MCOUNTINH: inh_d = stored[NCNT-1:0];
`endif
        default: ;
      endcase
    end

    if (trap_valid) begin
      mepc_d         = trap_pc & 32'hFFFF_FFFC;
      mcause_d       = trap_cause;
      mtval_d        = trap_val;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end

    // A CSR write to either half takes the place of that cycle's increment.
    cnt_run = 1'b0;
    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i] = cnt_q[i];
      cnt_run  = ((i == 0) ? 1'b1 : cnt_inc[i]) && !cnt_frozen[i];
      if (do_write && sel == SEL_CNT_LO && cnt_k == 5'(i)) begin
        cnt_d[i] = {cnt_q[i][63:32], stored};
      end else if (do_write && sel == SEL_CNT_HI && cnt_k == 5'(i)) begin
        cnt_d[i] = {stored, cnt_q[i][31:0]};
      end else if (cnt_run) begin
        cnt_d[i] = cnt_q[i] + 64'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= 32'd0;
      mtvec_q        <= 32'd0;
      mscratch_q     <= 32'd0;
      mepc_q         <= 32'd0;
      mcause_q       <= 32'd0;
      mtval_q        <= 32'd0;
      mip_q          <= 3'd0;
      irq_pending_q  <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= 32'd0;
      rsp_err_q      <= 1'b0;
`ifdef CSR_COUNTER_INHIBIT_EN
      inh_q          <= '0;
`endif
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= 64'd0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
      mip_q          <= mip_d;
      irq_pending_q  <= irq_pending_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
`ifdef CSR_COUNTER_INHIBIT_EN
      inh_q          <= inh_d;
`endif
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign irq_pending   = irq_pending_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, cnt_inc[0], trap_pc[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_csr_unit.sv
// ============================================================================
// Module      : tb_csr_unit
// Description : Self-checking bench for csr_unit (NCNT=5, HARTID=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  cnt_inc;
  logic        trap_valid;
  logic [31:0] trap_cause, trap_pc, trap_val;
  logic        mret;
  logic        irq_sw, irq_timer, irq_ext;
  logic [31:0] mtvec_o, mepc_o;
  logic        irq_pending;

  int checks   = 0;
  int failures = 0;

  csr_unit_if #(.XLEN(32)) bus ();

  csr_unit #(.XLEN(32), .NCNT(5), .HARTID(32'd3), .MISA_VAL(32'h4000_0100)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cnt_inc    (cnt_inc),
    .trap_valid (trap_valid),
    .trap_cause (trap_cause),
    .trap_pc    (trap_pc),
    .trap_val   (trap_val),
    .mret       (mret),
    .irq_sw     (irq_sw),
    .irq_timer  (irq_timer),
    .irq_ext    (irq_ext),
    .mtvec_o    (mtvec_o),
    .mepc_o     (mepc_o),
    .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request at a falling edge; response is sampled at the next falling edge.
  task automatic txn(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                     input logic wen, output logic vld, output logic [31:0] rd, output logic er);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_wen   = wen;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'b0;
    bus.req_op    = 2'b00;
    vld = bus.rsp_valid;
    rd  = bus.rsp_rdata;
    er  = bus.rsp_err;
  endtask

  task automatic txn_chk(input string name, input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] wd, input logic wen,
                         input logic [31:0] exp_rd, input logic exp_err);
    logic v, e;
    logic [31:0] r;
    txn(op, addr, wd, wen, v, r, e);
    chk({name, " valid"}, {63'd0, v}, 64'd1);
    chk({name, " rdata"}, {32'd0, r}, {32'd0, exp_rd});
    chk({name, " err"},   {63'd0, e}, {63'd0, exp_err});
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam logic [1:0] R = 2'b00, RW = 2'b01, RS = 2'b10, RC = 2'b11;

  vec_t vecs [33];

  initial begin
    logic v, e;
    logic [31:0] r;

    vecs[0]  = '{R,  12'h300, 32'h0,         1'b0, 1'b1, 32'h0000_1800, 1'b0};
    vecs[1]  = '{R,  12'hF14, 32'h0,         1'b0, 1'b1, 32'h0000_0003, 1'b0};
    vecs[2]  = '{R,  12'hF10, 32'h0,         1'b0, 1'b1, 32'h4000_0100, 1'b0};
    vecs[3]  = '{R,  12'hF11, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0};
    vecs[4]  = '{RW, 12'h305, 32'h8000_0007, 1'b1, 1'b1, 32'h0,         1'b0};
    vecs[5]  = '{R,  12'h305, 32'h0,         1'b0, 1'b1, 32'h8000_0004, 1'b0};
    vecs[6]  = '{RS, 12'h304, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0,         1'b0};
    vecs[7]  = '{R,  12'h304, 32'h0,         1'b0, 1'b1, 32'h0000_0888, 1'b0};
    vecs[8]  = '{RC, 12'h304, 32'h0000_0008, 1'b1, 1'b1, 32'h0000_0888, 1'b0};
    vecs[9]  = '{R,  12'h304, 32'h0,         1'b0, 1'b1, 32'h0000_0880, 1'b0};
    vecs[10] = '{RW, 12'h340, 32'h1234_5678, 1'b1, 1'b1, 32'h0,         1'b0};
    vecs[11] = '{RS, 12'h340, 32'h0000_000F, 1'b0, 1'b1, 32'h1234_5678, 1'b0};
    vecs[12] = '{R,  12'h340, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 1'b0};
    vecs[13] = '{RC, 12'h340, 32'hFFFF_0000, 1'b1, 1'b1, 32'h1234_5678, 1'b0};
    vecs[14] = '{R,  12'h340, 32'h0,         1'b0, 1'b1, 32'h0000_5678, 1'b0};
    vecs[15] = '{RW, 12'hF14, 32'h0000_0001, 1'b1, 1'b1, 32'h0,         1'b1};
    vecs[16] = '{R,  12'hB06, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1};
    vecs[17] = '{R,  12'hB01, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1};
    vecs[18] = '{R,  12'h7C0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1};
    vecs[19] = '{RW, 12'h344, 32'h0000_0FFF, 1'b1, 1'b1, 32'h0,         1'b0};
    vecs[20] = '{R,  12'h344, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0};
    vecs[21] = '{RW, 12'h300, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_1800, 1'b0};
    vecs[22] = '{R,  12'h300, 32'h0,         1'b0, 1'b1, 32'h0000_1888, 1'b0};
    vecs[23] = '{RC, 12'h300, 32'h0000_0088, 1'b1, 1'b1, 32'h0000_1888, 1'b0};
    vecs[24] = '{R,  12'h300, 32'h0,         1'b0, 1'b1, 32'h0000_1800, 1'b0};
    vecs[25] = '{RW, 12'h341, 32'h0000_0107, 1'b1, 1'b1, 32'h0,         1'b0};
    vecs[26] = '{R,  12'h341, 32'h0,         1'b0, 1'b1, 32'h0000_0104, 1'b0};
    vecs[27] = '{RW, 12'hB80, 32'h0000_0002, 1'b1, 1'b1, 32'h0,         1'b0};
    vecs[28] = '{RW, 12'hB00, 32'h0000_0100, 1'b1, 1'b0, 32'h0,         1'b0};
    vecs[29] = '{R,  12'hB00, 32'h0,         1'b0, 1'b1, 32'h0000_0100, 1'b0};
    vecs[30] = '{R,  12'hB00, 32'h0,         1'b0, 1'b1, 32'h0000_0101, 1'b0};
    vecs[31] = '{R,  12'hB80, 32'h0,         1'b0, 1'b1, 32'h0000_0002, 1'b0};
    vecs[32] = '{R,  12'hB05, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0};

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = 12'h0;
    bus.req_wdata = 32'h0; bus.req_wen = 1'b0;
    cnt_inc = 5'b0; trap_valid = 1'b0; trap_cause = 32'h0; trap_pc = 32'h0;
    trap_val = 32'h0; mret = 1'b0; irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("reset rsp_valid",   {63'd0, bus.rsp_valid}, 64'd0);
    chk("reset rsp_rdata",   {32'd0, bus.rsp_rdata}, 64'd0);
    chk("reset rsp_err",     {63'd0, bus.rsp_err},   64'd0);
    chk("reset irq_pending", {63'd0, irq_pending},   64'd0);
    chk("reset mtvec_o",     {32'd0, mtvec_o},       64'd0);
    chk("reset mepc_o",      {32'd0, mepc_o},        64'd0);

    // Back-to-back table
    for (int i = 0; i < 33; i++) begin
      txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].wen, v, r, e);
      chk($sformatf("vec%0d valid", i), {63'd0, v}, 64'd1);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d rdata", i), {32'd0, r}, {32'd0, vecs[i].exp_rd});
      chk($sformatf("vec%0d err", i), {63'd0, e}, {63'd0, vecs[i].exp_err});
    end
    chk("mtvec_o", {32'd0, mtvec_o}, 64'h8000_0004);
    chk("mepc_o",  {32'd0, mepc_o},  64'h0000_0104);

    // Counter 1 carry from low into high
    txn_chk("cnt1 wr lo", RW, 12'hB02, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);
    cnt_inc = 5'b00010;
    repeat (2) @(negedge clk);
    cnt_inc = 5'b0;
    txn_chk("cnt1 hi", R, 12'hB82, 32'h0, 1'b0, 32'h1, 1'b0);
    txn_chk("cnt1 lo", R, 12'hB02, 32'h0, 1'b0, 32'h1, 1'b0);

    // Trap with a same-cycle mepc write, then mret
    txn_chk("set MIE", RW, 12'h300, 32'h0000_0008, 1'b1, 32'h0000_1800, 1'b0);
    trap_valid = 1'b1; trap_pc = 32'h0000_0103; trap_cause = 32'h8000_000B; trap_val = 32'h0000_0055;
    txn_chk("trap mepc wr", RW, 12'h341, 32'hDEAD_0000, 1'b1, 32'h0000_0104, 1'b0);
    trap_valid = 1'b0;
    chk("trap mepc_o", {32'd0, mepc_o}, 64'h0000_0100);
    txn_chk("trap mstatus", R, 12'h300, 32'h0, 1'b0, 32'h0000_1880, 1'b0);
    txn_chk("trap mcause",  R, 12'h342, 32'h0, 1'b0, 32'h8000_000B, 1'b0);
    txn_chk("trap mtval",   R, 12'h343, 32'h0, 1'b0, 32'h0000_0055, 1'b0);
    mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
    txn_chk("mret mstatus", R, 12'h300, 32'h0, 1'b0, 32'h0000_1888, 1'b0);

    // External interrupt pending latency
    txn_chk("mie ext", RW, 12'h304, 32'h0000_0800, 1'b1, 32'h0000_0880, 1'b0);
    chk("irq idle", {63'd0, irq_pending}, 64'd0);
    irq_ext = 1'b1;
    @(negedge clk);
    chk("irq edge1", {63'd0, irq_pending}, 64'd0);
    @(negedge clk);
    chk("irq edge2", {63'd0, irq_pending}, 64'd1);
    txn_chk("mip ext", R, 12'h344, 32'h0, 1'b0, 32'h0000_0800, 1'b0);
    irq_ext = 1'b0;
    repeat (2) @(negedge clk);
    chk("irq clear", {63'd0, irq_pending}, 64'd0);

    // Counter inhibit
`ifdef CSR_COUNTER_INHIBIT_EN
    txn_chk("inh wr",  RW, 12'h320, 32'h0000_0004, 1'b1, 32'h0, 1'b0);
    txn_chk("inh rd",  R,  12'h320, 32'h0,         1'b0, 32'h0000_0004, 1'b0);
    cnt_inc = 5'b00100;
    repeat (3) @(negedge clk);
    cnt_inc = 5'b0;
    txn_chk("cnt2 frozen", R, 12'hB03, 32'h0, 1'b0, 32'h0, 1'b0);
    txn_chk("inh wr all", RW, 12'h320, 32'hFFFF_FFFF, 1'b1, 32'h0000_0004, 1'b0);
    txn_chk("inh masked", R,  12'h320, 32'h0,         1'b0, 32'h0000_001D, 1'b0);
`else
    txn_chk("inh unmapped", RW, 12'h320, 32'h0000_0004, 1'b1, 32'h0, 1'b1);
    cnt_inc = 5'b00100;
    repeat (3) @(negedge clk);
    cnt_inc = 5'b0;
    txn_chk("cnt2 runs", R, 12'hB03, 32'h0, 1'b0, 32'h3, 1'b0);
`endif

    // Reset during an outstanding request
    bus.req_valid = 1'b1; bus.req_op = R; bus.req_addr = 12'h300; bus.req_wen = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst mid rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst mid mepc_o",    {32'd0, mepc_o},        64'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    txn_chk("post rst mstatus", R, 12'h300, 32'h0, 1'b0, 32'h0000_1800, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/csr_unit.md
# csr_unit

Parametrised machine-mode CSR unit replacing the fixed-map CSR file in the core. It owns the machine trap CSRs, a bank of `NCNT` internal 64-bit hardware performance counters, and the interrupt-pending logic. It executes CSRRW/CSRRS/CSRRC read-modify-write requests with a one-cycle registered response. It sits beside the execute stage and receives trap/mret events from the pipeline controller.

## Interface
- `XLEN`, 32: data width; only 32 is supported.
- `NCNT`, 5: number of 64-bit counters, 1..30; counter 0 is the cycle counter.
- `HARTID`, 0: value read at 0xF14.
- `MISA_VAL`, 32'h4000_0100: value read at 0xF10 (RV32I).
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: CSR request strobe.
- `req_op` in 2: 01 RW, 10 RS (set), 11 RC (clear); 00 is read-only.
- `req_addr` in 12: CSR address.
- `req_wdata` in XLEN: operand.
- `req_wen` in 1: write intended; 0 suppresses the write (RS/RC with x0).
- `rsp_valid` out 1: response strobe, one cycle after `req_valid`.
- `rsp_rdata` out XLEN: old CSR value.
- `rsp_err` out 1: illegal access.
- `cnt_inc` in NCNT: per-counter increment event; bit 0 is ignored.
- `trap_valid` in 1: trap entry.
- `trap_cause`, `trap_pc`, `trap_val` in XLEN each: trap entry data.
- `mret` in 1: trap return.
- `irq_sw`, `irq_timer`, `irq_ext` in 1 each: interrupt lines.
- `mtvec_o`, `mepc_o` out XLEN: current register values.
- `irq_pending` out 1: enabled interrupt pending.

## Operation
- **Address map:**
  - 0x300 mstatus
  - 0x304 mie
  - 0x305 mtvec
  - 0x340 mscratch
  - 0x341 mepc
  - 0x342 mcause
  - 0x343 mtval
  - 0x344 mip
  - 0xF10–0xF14 misa/mvendorid(0)/marchid(0)/mimpid(0)/mhartid
  - Counter 0 low/high at 0xB00/0xB80.
  - Counter k≥1 low/high at 0xB01+k / 0xB81+k.
  - Every other address, and counter indices ≥ NCNT, is unmapped.
- **New value:**
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - Stored = (new & WMASK) | (old & ~WMASK).
- **Write masks:**
  - mstatus 0x0000_0088 (MIE bit 3, MPIE bit 7). MPP[12:11] always reads 2'b11.
  - mie 0x0000_0888.
  - mtvec and mepc 0xFFFF_FFFC.
  - mscratch, mcause, mtval, and counters: all ones.
  - mip and 0xF1x: read-only.
- **rsp_err = 1:** unmapped address, or `req_wen`=1 to 0xF10–0xF14. No state changes. `rsp_rdata`=0.
- **mip writes:** silently ignored; no error.
- **mip contents:** {20'b0, ext, 3'b0, timer, 3'b0, sw, 3'b0}, sampled every cycle.
- **Counters:**
  - Counter 0 increments every cycle; counter k increments when `cnt_inc[k]`.
  - 64-bit increment; low wrap from 0xFFFF_FFFF carries into the high half.
  - A CSR write to either half replaces that half; the counter does not increment that cycle.
- **Trap entry:**
  - mepc ← trap_pc & ~3; mcause ← trap_cause; mtval ← trap_val.
  - MPIE ← MIE; MIE ← 0.
- **mret:** MIE ← MPIE; MPIE ← 1.
- **Priority:**
  - trap_valid over mret.
  - trap/mret over a same-cycle CSR write to mstatus/mepc/mcause/mtval; that CSR write is dropped, but the response still returns the old value.
- **irq_pending:** registered mstatus.MIE & |(mip & mie).

## Timing
- **Reset values:**
  - All CSRs and counters 0, except constants.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `irq_pending`=0.
  - `mtvec_o`=0, `mepc_o`=0.
- **Request/response:** request sampled at edge N. At edge N+1: `rsp_valid`=1 with the pre-edge-N value (read-before-write), and the write lands.
- **Back-to-back:** requests every cycle are supported. A request at N+1 to the same CSR sees the value written at N.
- **Counter reads:** return the value before the increment of the sampling edge.
- **irq_pending latency:** 1 cycle after mip/mie/MIE change.
- **Reset mid-request:** the response is cancelled (`rsp_valid`=0).

## Configuration
- **`CSR_COUNTER_INHIBIT_EN` defined:**
  - Adds mcountinhibit at 0x320, write mask ((1<<NCNT)-1) & ~2, reset 0.
  - Bit k=1 freezes counter k; CSR writes still apply.
- **Undefined:** 0x320 is unmapped (`rsp_err`) and counters always run.

## Test plan
- Reset, then read 0x300 → `rsp_rdata`=0x0000_1800, `rsp_err`=0. Read 0xF14 with HARTID=3 → 3.
- RW 0x305 wdata=0x8000_0007, then read → 0x8000_0004. RS 0x304 0xFFFF_FFFF → mie=0x888. RC 0x304 0x008 → 0x880.
- Write counter 1 low 0xFFFF_FFFF, hold `cnt_inc[1]`=1 for 2 cycles → high=1, low=1.
- Trap with MIE=1, pc=0x103, cause=0x8000_000B, and a same-cycle write of 0x341 → mepc=0x100, MIE=0, MPIE=1. Then mret → MIE=1.
- MIE=1, mie=0x800, assert `irq_ext` → `irq_pending`=1 two edges later (mip sample, then pending register). Write 0xB00 with NCNT=5, and read 0xB06 → `rsp_err`=1.
- With the macro: write 0x320=0x4 → counter 2 frozen despite `cnt_inc[2]`. Without the macro: 0x320 → `rsp_err`=1.
